// File: rtl/bus_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bus_pkg
// Purpose  : Shared widths, state encodings and helpers for the system-bus demo.
// Revision : 1.0 - initial release
// ============================================================================
package bus_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;
    localparam int LEN_W  = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GRANT_M1 = 2'd1,
        GRANT_M2 = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        M_IDLE = 2'd0,
        M_REQ  = 2'd1,
        M_ADDR = 2'd2,
        M_DATA = 2'd3
    } mst_state_t;

    // A zero length field still moves one beat.
    function automatic logic [LEN_W-1:0] beat_count(input logic [LEN_W-1:0] len);
        return (len == '0) ? LEN_W'(1) : len;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bus_master.sv
`default_nettype none
// ============================================================================
// Module   : bus_master
// Purpose  : Button-started burst master; ADDR and DATA phase one tick each.
// Revision : 1.0 - initial release
// ============================================================================
module bus_master #(
    parameter int ADDR_W = bus_pkg::ADDR_W,
    parameter int DATA_W = bus_pkg::DATA_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_tick,
    input  logic                      i_start,
    input  logic                      i_rw,
    input  logic [ADDR_W-1:0]         i_start_addr,
    input  logic [bus_pkg::LEN_W-1:0] i_burst_len,
    input  logic                      i_grant,
    input  logic [DATA_W-1:0]         i_rd_data,
    output logic                      o_req,
    output logic                      o_done,
    output logic                      o_busy,
    output logic [ADDR_W-1:0]         o_bus_addr,
    output logic [DATA_W-1:0]         o_bus_wdata,
    output logic                      o_bus_we,
    output logic                      o_bus_data
);
    import bus_pkg::*;

    mst_state_t         r_state;
    logic               r_busy;
    logic               r_rw;
    logic [ADDR_W-1:0]  r_addr;
    logic [LEN_W-1:0]   r_remain;
    logic [DATA_W-1:0]  r_rd_last;

    // A fresh start requests in the same tick so a free bus grants with no gap.
    assign o_req       = (r_state == M_REQ) || ((r_state == M_IDLE) && i_start);
    assign o_done      = i_tick && (r_state == M_DATA) && (r_remain == LEN_W'(1));
    assign o_busy      = r_busy;
    assign o_bus_addr  = r_addr;
    assign o_bus_wdata = DATA_W'(r_addr + ADDR_W'(1));
    assign o_bus_we    = ~r_rw;
    assign o_bus_data  = (r_state == M_DATA);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= M_IDLE;
            r_busy    <= 1'b0;
            r_rw      <= 1'b0;
            r_addr    <= '0;
            r_remain  <= '0;
            r_rd_last <= '0;
        end else if (i_tick) begin
            case (r_state)
                M_IDLE: begin
                    if (i_start) begin
                        r_rw     <= i_rw;
                        r_addr   <= i_start_addr;
                        r_remain <= beat_count(i_burst_len);
                        r_busy   <= 1'b1;
                        r_state  <= i_grant ? M_ADDR : M_REQ;
                    end
                end
                M_REQ: begin
                    if (i_grant) begin
                        r_state <= M_ADDR;
                    end
                end
                M_ADDR: begin
                    r_state <= M_DATA;
                end
                M_DATA: begin
                    if (r_rw) begin
                        r_rd_last <= i_rd_data;
                    end
                    if (r_remain == LEN_W'(1)) begin
                        r_state <= M_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_remain <= r_remain - LEN_W'(1);
                        r_addr   <= r_addr + ADDR_W'(1);
                        r_state  <= M_ADDR;
                    end
                end
                default: begin
                    r_state <= M_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/top.sv
`default_nettype none
// ============================================================================
// Module   : top
// Purpose  : System-bus demo: tick divider, button conditioning, config register,
//            fixed-priority arbiter, 256x8 memory and two burst masters.
// Revision : 1.0 - initial release
// ============================================================================
module top #(
    parameter int CLK_DIV = 10,
    parameter int ADDR_W  = bus_pkg::ADDR_W,
    parameter int DATA_W  = bus_pkg::DATA_W
) (
    input  logic                             clock,
    input  logic                             rst,
    input  logic                             enable,
    input  logic                             button1_raw,
    input  logic                             button2_raw,
    input  logic                             button3_raw,
    input  logic                             mode_switch,
    input  logic                             rw_switch1,
    input  logic                             rw_switch2,
    input  logic [ADDR_W+bus_pkg::LEN_W-1:0] switch_array,
    output logic                             m1_busy,
    output logic                             m2_busy,
    output logic                             scaled_clk
);
    import bus_pkg::*;

    localparam int c_half  = CLK_DIV / 2;
    localparam int c_cnt_w = (c_half > 1) ? $clog2(c_half) : 1;
    localparam int c_cfg_w = ADDR_W + LEN_W;

    // ---------------- tick divider ----------------
    logic [c_cnt_w-1:0] r_div_cnt;
    logic               r_scaled_clk;
    logic               r_tick;
    logic               w_wrap;
    logic               w_tick;

    assign w_wrap = (r_div_cnt == c_cnt_w'(c_half - 1));
    // r_tick is held while frozen so a pending tick survives an enable drop.
    assign w_tick = r_tick & enable;

    always_ff @(posedge clock) begin
        if (rst) begin
            r_div_cnt    <= '0;
            r_scaled_clk <= 1'b0;
            r_tick       <= 1'b0;
        end else if (enable) begin
            r_tick <= w_wrap & ~r_scaled_clk;
            if (w_wrap) begin
                r_div_cnt    <= '0;
                r_scaled_clk <= ~r_scaled_clk;
            end else begin
                r_div_cnt <= r_div_cnt + c_cnt_w'(1);
            end
        end
    end

    // ---------------- button conditioning ----------------
    logic [2:0] r_sync1;
    logic [2:0] r_sync2;
    logic [2:0] r_btn_smp;
    logic [1:0] w_press;
    logic       w_cfg_release;

    always_ff @(posedge clock) begin
        if (rst) begin
            r_sync1   <= '1;
            r_sync2   <= '1;
            r_btn_smp <= '1;
        end else if (enable) begin
            r_sync1 <= {button3_raw, button2_raw, button1_raw};
            r_sync2 <= r_sync1;
            if (w_tick) begin
                r_btn_smp <= r_sync2;
            end
        end
    end

    assign w_press       = {2{w_tick}} & r_btn_smp[1:0] & ~r_sync2[1:0];
    assign w_cfg_release = w_tick & ~r_btn_smp[2] & r_sync2[2];

    // ---------------- configuration ----------------
    logic [c_cfg_w-1:0] r_cfg;

    always_ff @(posedge clock) begin
        if (rst) begin
            r_cfg <= '0;
        end else if (w_cfg_release && !mode_switch) begin
            r_cfg <= switch_array;
        end
    end

    // ---------------- arbiter ----------------
    arb_state_t r_arb;
    logic       w_req1;
    logic       w_req2;
    logic       w_done1;
    logic       w_done2;
    logic       w_grant1;
    logic       w_grant2;

    assign w_grant1 = w_tick && (r_arb == IDLE) && w_req1;
    assign w_grant2 = w_tick && (r_arb == IDLE) && !w_req1 && w_req2;

    always_ff @(posedge clock) begin
        if (rst) begin
            r_arb <= IDLE;
        end else if (w_tick) begin
            case (r_arb)
                IDLE: begin
                    if (w_req1) begin
                        r_arb <= GRANT_M1;
                    end else if (w_req2) begin
                        r_arb <= GRANT_M2;
                    end
                end
                GRANT_M1: if (w_done1) r_arb <= IDLE;
                GRANT_M2: if (w_done2) r_arb <= IDLE;
                default:  r_arb <= IDLE;
            endcase
        end
    end

    // ---------------- bus mux and memory ----------------
    logic [ADDR_W-1:0] w_addr1, w_addr2, w_bus_addr;
    logic [DATA_W-1:0] w_wdata1, w_wdata2, w_bus_wdata, w_rd_data;
    logic              w_we1, w_we2, w_bus_we;
    logic              w_data1, w_data2, w_bus_data;
    logic              w_mem_write;
    logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];

    always_comb begin
        w_bus_addr  = w_addr1;
        w_bus_wdata = w_wdata1;
        w_bus_we    = w_we1;
        w_bus_data  = w_data1 && (r_arb == GRANT_M1);
        if (r_arb == GRANT_M2) begin
            w_bus_addr  = w_addr2;
            w_bus_wdata = w_wdata2;
            w_bus_we    = w_we2;
            w_bus_data  = w_data2;
        end
    end

    // The access lands on the tick that closes the DATA phase.
    assign w_mem_write = w_tick && w_bus_data && w_bus_we && !rst;
    assign w_rd_data   = r_mem[w_bus_addr];

    always_ff @(posedge clock) begin
        if (w_mem_write) begin
            r_mem[w_bus_addr] <= w_bus_wdata;
        end
    end

    // ---------------- masters ----------------
    bus_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_master1 (
        .clk          (clock),
        .rst          (rst),
        .i_tick       (w_tick),
        .i_start      (w_press[0] && mode_switch),
        .i_rw         (rw_switch1),
        .i_start_addr (r_cfg[c_cfg_w-1:LEN_W]),
        .i_burst_len  (r_cfg[LEN_W-1:0]),
        .i_grant      (w_grant1),
        .i_rd_data    (w_rd_data),
        .o_req        (w_req1),
        .o_done       (w_done1),
        .o_busy       (m1_busy),
        .o_bus_addr   (w_addr1),
        .o_bus_wdata  (w_wdata1),
        .o_bus_we     (w_we1),
        .o_bus_data   (w_data1)
    );

    bus_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_master2 (
        .clk          (clock),
        .rst          (rst),
        .i_tick       (w_tick),
        .i_start      (w_press[1] && mode_switch),
        .i_rw         (rw_switch2),
        .i_start_addr (r_cfg[c_cfg_w-1:LEN_W]),
        .i_burst_len  (r_cfg[LEN_W-1:0]),
        .i_grant      (w_grant2),
        .i_rd_data    (w_rd_data),
        .o_req        (w_req2),
        .o_done       (w_done2),
        .o_busy       (m2_busy),
        .o_bus_addr   (w_addr2),
        .o_bus_wdata  (w_wdata2),
        .o_bus_we     (w_we2),
        .o_bus_data   (w_data2)
    );

    assign scaled_clk = r_scaled_clk;

endmodule
`default_nettype wire

// File: tb/tb_top.sv
`default_nettype none
// ============================================================================
// Module   : tb_top
// Purpose  : Randomized self-checking bench for the system-bus demo top.
// Revision : 1.0 - initial release
// ============================================================================
module tb_top;

    localparam int CLK_DIV    = 10;
    localparam int CLK_PERIOD = 20;

    logic        clock = 1'b0;
    logic        rst   = 1'b1;
    logic        enable = 1'b1;
    logic        b1 = 1'b1, b2 = 1'b1, b3 = 1'b1;
    logic        mode = 1'b0, rw1 = 1'b0, rw2 = 1'b0;
    logic [11:0] sw = '0;
    logic        m1_busy, m2_busy, scaled_clk;

    top #(.CLK_DIV(CLK_DIV)) dut (
        .clock        (clock),
        .rst          (rst),
        .enable       (enable),
        .button1_raw  (b1),
        .button2_raw  (b2),
        .button3_raw  (b3),
        .mode_switch  (mode),
        .rw_switch1   (rw1),
        .rw_switch2   (rw2),
        .switch_array (sw),
        .m1_busy      (m1_busy),
        .m2_busy      (m2_busy),
        .scaled_clk   (scaled_clk)
    );

    always #(CLK_PERIOD/2) clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: memory image, validity, and the loaded config word.
    logic [7:0]  ref_mem [256];
    bit          ref_vld [256];
    logic [11:0] ref_cfg = '0;

    function automatic int beats_of(input logic [11:0] c);
        return (c[3:0] == 4'd0) ? 1 : int'(c[3:0]);
    endfunction

    task automatic ticks(input int n);
        repeat (n * CLK_DIV) @(negedge clock);
    endtask

    task automatic load_cfg(input logic [11:0] at_press, input logic [11:0] at_release);
        @(negedge clock);
        mode = 1'b0;
        sw   = at_press;
        b3   = 1'b0;
        ticks(3);
        sw = at_release;
        ticks(2);
        b3 = 1'b1;
        ticks(3);
        ref_cfg = at_release;
        check_eq("cfg", 32'(dut.r_cfg), 32'(ref_cfg));
    endtask

    task automatic wait_m1(input bit level, input int bound, output int n);
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (m1_busy !== level && n < bound);
        check_eq("wait_m1_busy", 32'(m1_busy), 32'(level));
    endtask

    task automatic apply_model(input int m, input bit rd);
        logic [7:0] a;
        a = '0;
        for (int k = 0; k < beats_of(ref_cfg); k++) begin
            a = 8'(int'(ref_cfg[11:4]) + k);
            if (!rd) begin
                ref_mem[a] = 8'(int'(a) + 1);
                ref_vld[a] = 1'b1;
                check_eq($sformatf("mem[%0d]", a), 32'(dut.r_mem[a]), 32'(ref_mem[a]));
            end
        end
        if (rd && ref_vld[a]) begin
            if (m == 1) check_eq("m1_rd_last", 32'(dut.u_master1.r_rd_last), 32'(ref_mem[a]));
            else        check_eq("m2_rd_last", 32'(dut.u_master2.r_rd_last), 32'(ref_mem[a]));
        end
    endtask

    task automatic do_burst(input bit go1, input bit go2, input bit r1, input bit r2);
        int  c1, c2, b;
        bit  seen1, seen2, fin1, fin2;
        c1 = 0; c2 = 0; seen1 = 0; seen2 = 0;
        fin1 = !go1; fin2 = !go2;
        @(negedge clock);
        mode = 1'b1; rw1 = r1; rw2 = r2;
        b1 = !go1; b2 = !go2;
        for (int i = 0; i < 90 * CLK_DIV && !(fin1 && fin2); i++) begin
            @(negedge clock);
            if (m1_busy) begin seen1 = 1; c1++; b1 = 1'b1; end
            else if (seen1) fin1 = 1;
            if (m2_busy) begin seen2 = 1; c2++; b2 = 1'b1; end
            else if (seen2) fin2 = 1;
        end
        b1 = 1'b1; b2 = 1'b1;
        check_eq("burst_done", 32'(fin1 && fin2), 32'd1);
        b = beats_of(ref_cfg);
        // Master 2 waits out master 1's burst plus the arbiter's return through IDLE.
        check_eq("m1_busy_cycles", c1, go1 ? 2 * b * CLK_DIV : 0);
        check_eq("m2_busy_cycles", c2, go2 ? (go1 ? 4 * b + 1 : 2 * b) * CLK_DIV : 0);
        if (go1) apply_model(1, r1);
        if (go2) apply_model(2, r2);
    endtask

    initial begin
        int first, second, n, sel;
        logic sc;
        logic [11:0] rc;

        // Reset
        repeat (10) @(negedge clock);
        check_eq("rst_scaled_clk", 32'(scaled_clk), 32'd0);
        check_eq("rst_m1_busy", 32'(m1_busy), 32'd0);
        check_eq("rst_m2_busy", 32'(m2_busy), 32'd0);
        check_eq("rst_cfg", 32'(dut.r_cfg), 32'd0);
        rst = 1'b0;

        first = -1; second = -1; sc = 1'b0;
        for (int i = 0; i < 4 * CLK_DIV && second < 0; i++) begin
            @(negedge clock);
            if (scaled_clk && !sc) begin
                if (first < 0) first = i;
                else           second = i;
            end
            sc = scaled_clk;
        end
        check_eq("scaled_period_ns", (second - first) * CLK_PERIOD, 200);

        // Single transfers; value at release is what loads
        load_cfg(12'd10, 12'd0);
        do_burst(1, 0, 0, 0);
        check_eq("mem0_single", 32'(dut.r_mem[0]), 32'h01);
        do_burst(1, 0, 1, 0);
        check_eq("rd_last_single", 32'(dut.u_master1.r_rd_last), 32'h01);

        // Ten-beat burst
        load_cfg(12'd10, 12'd10);
        do_burst(1, 0, 0, 0);
        do_burst(1, 0, 1, 0);
        check_eq("rd_last_burst", 32'(dut.u_master1.r_rd_last), 32'h0A);

        // Simultaneous press, wrapping address range
        load_cfg(12'hFF5, 12'hFF5);
        do_burst(1, 1, 0, 1);
        check_eq("mem255_wrap", 32'(dut.r_mem[255]), 32'h00);
        check_eq("rd_last_m2_wrap", 32'(dut.u_master2.r_rd_last), 32'h04);

        // Freeze mid-burst
        load_cfg(12'h305, 12'h305);
        @(negedge clock);
        mode = 1'b1; rw1 = 1'b0; b1 = 1'b0;
        wait_m1(1'b1, 4 * CLK_DIV, n);
        b1 = 1'b1;
        repeat (25) @(negedge clock);
        enable = 1'b0;
        sc = scaled_clk;
        repeat (40) @(negedge clock);
        check_eq("frozen_scaled_clk", 32'(scaled_clk), 32'(sc));
        check_eq("frozen_busy", 32'(m1_busy), 32'd1);
        enable = 1'b1;
        wait_m1(1'b0, 200, n);
        check_eq("freeze_busy_cycles", 65 + n, 2 * 5 * CLK_DIV + 40);
        apply_model(1, 1'b0);

        // Reset mid-burst
        @(negedge clock);
        rw1 = 1'b1; b1 = 1'b0;
        wait_m1(1'b1, 4 * CLK_DIV, n);
        b1 = 1'b1;
        repeat (15) @(negedge clock);
        rst = 1'b1;
        @(negedge clock);
        check_eq("midrst_m1_busy", 32'(m1_busy), 32'd0);
        check_eq("midrst_scaled_clk", 32'(scaled_clk), 32'd0);
        check_eq("midrst_cfg", 32'(dut.r_cfg), 32'd0);
        rst = 1'b0;
        ref_cfg = '0;

        // Randomized configs and master mixes
        for (int it = 0; it < 6; it++) begin
            rc = 12'($urandom);
            load_cfg(12'($urandom), rc);
            sel = int'($urandom_range(1, 3));
            do_burst(sel[0], sel[1], 1'($urandom), 1'($urandom));
            do_burst(1, 1, 0, 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
`default_nettype wire
